// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, configurable frame format and a
// receive FIFO with valid/ready output and sticky error flags.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  input  logic                          err_clear
);

  localparam int CLKS_PER_TICK = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int AW            = $clog2(FIFO_DEPTH);
  localparam int BW            = $clog2(DATA_BITS);

  generate
    if (CLKS_PER_TICK < 1) begin : g_bad_divider
      $error("uart_rx_fifo: CLOCK_FREQ too low for BAUD_RATE*16");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_format
      $error("uart_rx_fifo: illegal frame format or FIFO depth");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_e;

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  logic [1:0]           sync_q, sync_d;
  logic                 rxs;
  state_e               state_q, state_d;
  logic [3:0]           phase_q, phase_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 mid, par_exp;
  logic                 commit, frame_evt, parity_evt, overrun_evt;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level;
  logic                 full, push, pop;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_err_q, overrun_err_d;

  assign tick    = (div_q == DIV_W'(CLKS_PER_TICK - 1));
  assign div_d   = tick ? '0 : div_q + DIV_W'(1);
  assign sync_d  = {sync_q[0], rxd};
  assign rxs     = sync_q[1];
  assign mid     = tick && (phase_q == 4'd7);
  assign par_exp = (PARITY == 1) ? ~(^shift_q) : ^shift_q;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    stop_idx_d = stop_idx_q;
    commit     = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    if (tick && state_q != S_IDLE) phase_d = phase_q + 4'd1;
    case (state_q)
      S_IDLE: if (tick && !rxs) begin
        state_d   = S_START;
        phase_d   = 4'd0;
        par_bad_d = 1'b0;
      end
      S_START: if (mid) begin
        if (rxs) state_d = S_IDLE;
        else begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: if (mid) begin
        shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + BW'(1);
        if (bit_idx_q == BW'(DATA_BITS - 1)) begin
          state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          stop_idx_d = 1'b0;
        end
      end
      S_PARITY: if (mid) begin
        if (rxs != par_exp) begin
          par_bad_d  = 1'b1;
          parity_evt = 1'b1;
        end
        state_d = S_STOP;
      end
      S_STOP: if (mid) begin
        if (!rxs) begin
          frame_evt = 1'b1;
          state_d   = S_WAIT_IDLE;
        end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
          commit  = !par_bad_q;
          state_d = S_IDLE;
        end else begin
          stop_idx_d = 1'b1;
        end
      end
      // A held-low line (break) must return high before a new start is looked for.
      S_WAIT_IDLE: if (tick && rxs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign level       = wr_ptr_q - rd_ptr_q;
  assign full        = (level == (AW + 1)'(FIFO_DEPTH));
  assign out_valid   = (level != '0);
  assign pop         = out_valid && out_ready;
  assign push        = commit && (!full || pop);
  assign overrun_evt = commit && full && !pop;
  assign out_data    = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_level    = level;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = shift_q;
      wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
  end

  // A new event wins over a clear arriving in the same cycle.
  assign frame_err_d   = frame_evt   | (frame_err_q   & ~err_clear);
  assign parity_err_d  = parity_evt  | (parity_err_q  & ~err_clear);
  assign overrun_err_d = overrun_evt | (overrun_err_q & ~err_clear);

  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q         <= '0;
      sync_q        <= 2'b11;
      state_q       <= S_IDLE;
      phase_q       <= 4'd0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      stop_idx_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
      // NOTE: the storage is reset so the head word reads 0, not X, when empty after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      div_q         <= div_d;
      sync_q        <= sync_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      stop_idx_q    <= stop_idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: three instances (8N1, 8E2, 9N1) at
// 16 clk per bit, a scoreboard queue per instance and a vector table for 8E2.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rxd_a, rxd_b, rxd_c;
  logic       ready_a, ready_b, ready_c;
  logic       clr_a, clr_b, clr_c;
  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic       valid_a, valid_b, valid_c;
  logic [2:0] level_a, level_b, level_c;
  logic       ferr_a, perr_a, oerr_a;
  logic       ferr_b, perr_b, oerr_b;
  logic       ferr_c, perr_c, oerr_c;

  uart_rx_fifo #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .rx_level(level_a), .frame_err(ferr_a),
    .parity_err(perr_a), .overrun_err(oerr_a), .err_clear(clr_a));

  uart_rx_fifo #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(ready_b), .rx_level(level_b), .frame_err(ferr_b),
    .parity_err(perr_b), .overrun_err(oerr_b), .err_clear(clr_b));

  uart_rx_fifo #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(9),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .rxd(rxd_c), .out_data(data_c), .out_valid(valid_c),
    .out_ready(ready_c), .rx_level(level_c), .frame_err(ferr_c),
    .parity_err(perr_c), .overrun_err(oerr_c), .err_clear(clr_c));

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit [1:0]   stops;   // bit 0 = first stop bit on the line
    bit         push;
    bit         perr;
    bit         ferr;
  } vec_t;

  vec_t       vecs [6];
  logic [8:0] exp_a [$];
  logic [8:0] exp_b [$];
  logic [8:0] exp_c [$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic take(input string name, input logic [8:0] act, inout logic [8:0] q [$]);
    logic [8:0] e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unexpected word 0x%0h expected none", name, act);
    end else begin
      e = q.pop_front();
      check(name, 32'(act), 32'(e));
    end
  endtask

  // Sample on the falling edge; a valid&&ready seen here is popped on the next rising edge.
  task automatic poll();
    if (valid_a && ready_a) take("word_a", {1'b0, data_a}, exp_a);
    if (valid_b && ready_b) take("word_b", {1'b0, data_b}, exp_b);
    if (valid_c && ready_c) take("word_c", data_c, exp_c);
  endtask

  task automatic cycle();
    @(negedge clk);
    poll();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bits(input int n);
    repeat (16 * n) cycle();
  endtask

  task automatic set_rxd(input int sel, input logic v);
    case (sel)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input int par, input bit bad_par, input bit [1:0] stops,
                            input int nstop);
    logic p;
    set_rxd(sel, 1'b0);
    wait_bits(1);
    p = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      p = p ^ data[i];
      set_rxd(sel, data[i]);
      wait_bits(1);
    end
    if (par != 0) begin
      if (par == 1) p = ~p;
      if (bad_par) p = ~p;
      set_rxd(sel, p);
      wait_bits(1);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rxd(sel, stops[i]);
      wait_bits(1);
    end
    set_rxd(sel, 1'b1);
  endtask

  initial begin
    vecs[0] = '{8'h07, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hC3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    ready_a = 1'b0; ready_b = 1'b1; ready_c = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    repeat (5) cycle();
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_data_a",  32'(data_a),  32'd0);
    check("rst_level_a", 32'(level_a), 32'd0);
    check("rst_flags_a", 32'({ferr_a, perr_a, oerr_a}), 32'd0);
    check("rst_flags_b", 32'({ferr_b, perr_b, oerr_b}), 32'd0);
    check("rst_data_c",  32'(data_c),  32'd0);
    rst = 1'b1;
    wait_bits(1);

    // 8N1 stream with the consumer always ready.
    ready_a = 1'b1;
    exp_a.push_back(9'h0A5);
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
    exp_a.push_back(9'h03C);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
    wait_bits(2);
    check("pending_a_stream", 32'(exp_a.size()), 32'd0);
    check("flags_a_stream", 32'({ferr_a, perr_a, oerr_a}), 32'd0);

    // Overrun: five frames into a four-entry FIFO with no consumer.
    ready_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_a.push_back(9'(i));
      send_frame(0, 9'(i), 8, 0, 1'b0, 2'b11, 1);
      wait_bits(1);
    end
    check("ovr_level", 32'(level_a), 32'd4);
    check("ovr_flag",  32'(oerr_a),  32'd1);
    check("ovr_head",  32'(data_a),  32'h01);
    ready_a = 1'b1;
    repeat (4) cycle();
    check("ovr_drain_level", 32'(level_a), 32'd0);
    check("ovr_pending", 32'(exp_a.size()), 32'd0);
    clr_a = 1'b1;
    cycle();
    clr_a = 1'b0;
    check("ovr_cleared", 32'(oerr_a), 32'd0);

    // Three-clock glitch on an idle line is a false start.
    set_rxd(0, 1'b0);
    repeat (3) cycle();
    set_rxd(0, 1'b1);
    wait_bits(2);
    check("glitch_level", 32'(level_a), 32'd0);
    check("glitch_flags", 32'({ferr_a, perr_a, oerr_a}), 32'd0);

    // 8E2 vector table: parity and stop-bit errors.
    for (int i = 0; i < 6; i++) begin
      clr_b = 1'b1;
      cycle();
      clr_b = 1'b0;
      if (vecs[i].push) exp_b.push_back({1'b0, vecs[i].data});
      send_frame(1, {1'b0, vecs[i].data}, 8, 2, vecs[i].bad_par, vecs[i].stops, 2);
      wait_bits(2);
      check($sformatf("vec%0d_perr", i), 32'(perr_b), 32'(vecs[i].perr));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_b), 32'(vecs[i].ferr));
      check($sformatf("vec%0d_pending", i), 32'(exp_b.size()), 32'd0);
      check($sformatf("vec%0d_level", i), 32'(level_b), 32'd0);
    end

    // Break: second stop bit low, line held low for 100 bit times.
    clr_b = 1'b1;
    cycle();
    clr_b = 1'b0;
    send_frame(1, 9'h0C3, 8, 2, 1'b0, 2'b01, 2);
    set_rxd(1, 1'b0);
    cycle();
    check("break_ferr", 32'(ferr_b), 32'd1);
    clr_b = 1'b1;
    cycle();
    clr_b = 1'b0;
    wait_bits(100);
    check("break_no_refire", 32'(ferr_b), 32'd0);
    check("break_level", 32'(level_b), 32'd0);
    set_rxd(1, 1'b1);
    wait_bits(2);
    exp_b.push_back(9'h055);
    send_frame(1, 9'h055, 8, 2, 1'b0, 2'b11, 2);
    wait_bits(2);
    check("break_recover", 32'(exp_b.size()), 32'd0);

    // Nine data bits.
    exp_c.push_back(9'h1FF);
    send_frame(2, 9'h1FF, 9, 0, 1'b0, 2'b11, 1);
    exp_c.push_back(9'h100);
    send_frame(2, 9'h100, 9, 0, 1'b0, 2'b11, 1);
    wait_bits(2);
    check("nine_pending", 32'(exp_c.size()), 32'd0);
    check("nine_flags", 32'({ferr_c, perr_c, oerr_c}), 32'd0);

    // Reset mid-frame with two words buffered.
    ready_a = 1'b0;
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
    wait_bits(1);
    check("pre_rst_level", 32'(level_a), 32'd2);
    set_rxd(0, 1'b0);
    wait_bits(1);
    set_rxd(0, 1'b1);
    repeat (8) cycle();
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_data",  32'(data_a),  32'd0);
    check("midrst_level", 32'(level_a), 32'd0);
    repeat (3) cycle();
    rst = 1'b1;
    wait_bits(2);
    check("post_rst_level", 32'(level_a), 32'd0);
    ready_a = 1'b1;
    exp_a.push_back(9'h05A);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1);
    wait_bits(2);
    check("post_rst_pending", 32'(exp_a.size()), 32'd0);
    check("post_rst_flags", 32'({ferr_a, perr_a, oerr_a}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with 16x oversampling, configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits) and an integrated receive FIFO with a valid/ready output. It sits behind the board shell's `uart_txd_in` pin and feeds received words to the on-chip host interface. It supersedes the fixed 8N1, single-buffer receive path, adding parity checking, framing/overrun error reporting and buffering.

## Interface
- `CLOCK_FREQ`, 100_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in baud.
- `DATA_BITS`, 8: payload bits per frame, legal 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 16: entries, power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  serial line, idle high, asynchronous to clk.
- `out_data`  out  DATA_BITS  FIFO head word, first received bit in bit 0.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head when high with out_valid.
- `rx_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `frame_err`, `parity_err`, `overrun_err`  out  1 each  sticky error flags.
- `err_clear`  in  1  single-cycle pulse clears all sticky flags.

## Operation
- Oversample tick: counter divides clk by `CLKS_PER_TICK = CLOCK_FREQ / (BAUD_RATE*16)`, integer truncation; elaboration fails if result < 1. Divider resets to 0 and free-runs; bit-phase counter (0–15) is re-aligned on start detection.
- `rxd` passes through a 2-FF synchroniser, both flops reset to 1. All sampling uses the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on `rxs` = 0 at a tick, go to START with phase = 0.
  - START: at phase 7 (mid-bit), `rxs` = 1 → false start, back to IDLE; else go to DATA, bit index = 0.
  - DATA: sample every 16 ticks at mid-bit, shift in LSB first; after DATA_BITS samples go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample; mismatch against odd/even parity of the payload marks the frame bad-parity.
  - STOP: sample each of STOP_BITS mid-bits; any 0 → frame error, word discarded, go to WAIT_IDLE. All 1 → commit word, go to IDLE.
  - WAIT_IDLE: stay until `rxs` = 1 at a tick, then IDLE (prevents a break condition from producing repeated frames).
- Parity-bad frames set `parity_err` and are discarded (not written to the FIFO).
- Commit: write to FIFO. If full and no pop in the same cycle, the new word is dropped and `overrun_err` set; FIFO contents are untouched. Full with simultaneous pop: write accepted, level unchanged.
- FIFO: pop on `out_valid && out_ready`. `out_data` is combinationally the head entry; undefined-free: reads 0 when empty after reset, otherwise holds stale data when empty (consumer ignores it).
- Sticky flags: set by event, cleared by `err_clear`; event and clear in the same cycle → flag ends set.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `rx_level` 0, all error flags 0, FSM IDLE, pointers 0.
- Reset asserted mid-frame aborts the frame immediately; FIFO empties; the first frame after release needs a fresh falling edge.
- Latency: `out_valid` rises the clock cycle after the final stop-bit mid-sample tick; total delay from the physical `rxd` edge includes 2 synchroniser cycles.
- `rx_level` updates on the same edge as the write/pop; push+pop same cycle leaves it unchanged.
- Error flags assert on the clock edge after the detecting sample.
- `out_ready` may be held high permanently; back-to-back pops sustain one word per cycle.

## Test plan
- CLOCK_FREQ 16_000_000, BAUD 1_000_000 (1 clk/tick, 16 clk/bit), 8N1: send 0xA5, 0x3C with out_ready = 1 → two words 0xA5, 0x3C out in order, no error flags.
- Same, out_ready = 0, FIFO_DEPTH 4, send 5 frames 0x01–0x05 → rx_level = 4, `overrun_err` = 1, pops return 0x01–0x04; `err_clear` pulse → flag 0.
- PARITY = 2, 8E1: send 0x07 with parity bit 0 (wrong) → `parity_err` = 1, nothing written; then 0x07 with parity 1 → word 0x07 delivered.
- STOP_BITS = 2: second stop bit driven 0 → `frame_err` = 1, no word; hold `rxd` low 100 bit times → no further frames; release then send 0x55 → 0x55 delivered.
- Glitch: 3-clk low pulse on idle `rxd` → false start, no word, no error; DATA_BITS = 9, send 0x1FF → out_data = 0x1FF.
- Assert `rst` low mid-data-bit of a frame with 2 words buffered → outputs at reset values immediately, next full frame 0x5A received correctly.
